// File: rtl/haze_pkg.sv
// Shared types and constants for the two-pass haze-removal pipeline.
package haze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS1,
        ST_WAIT_ALE,
        ST_PASS2,
        ST_DRAIN
    } haze_seq_state_t;

    localparam logic PASS_ALE = 1'b0;
    localparam logic PASS_TE  = 1'b1;

    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;

endpackage

// File: rtl/haze_beat_counter.sv
// Beat counter with synchronous clear; flags the final beat of a frame.
module haze_beat_counter #(
    parameter int W = 19,
    parameter int N = 262144
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign last = (cnt == W'(N - 1));

endmodule

// File: rtl/haze_pass_sequencer.sv
// Frame controller: pass 1 feeds ALE, pass 2 feeds TE/SRSC,
// counts output beats, generates TLAST and flags framing errors.
module haze_pass_sequencer
    import haze_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = $clog2(IMG_WIDTH * IMG_HEIGHT) + 1
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic enable,
    input  logic S_AXIS_TVALID,
    input  logic S_AXIS_TLAST,
    output logic S_AXIS_TREADY,
    input  logic M_AXIS_TREADY,
    output logic M_AXIS_TLAST,
    input  logic dp_out_valid,
    input  logic ale_done,
    output logic ale_en,
    output logic te_en,
    output logic dp_stall,
    output logic pass_sel,
    output logic frame_done,
    output logic busy,
    output logic err_framing
);

    localparam int N = IMG_WIDTH * IMG_HEIGHT;

    haze_seq_state_t state, state_nxt;

    logic accept;
    logic in_clr, out_clr;
    logic out_xfer;
    logic in_last, out_last;
    logic out_seen;
    logic done_nxt;
    logic err_hit;

    haze_beat_counter #(.W(CNT_W), .N(N)) u_in_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clr   (in_clr),
        .inc   (accept),
        .last  (in_last)
    );

    haze_beat_counter #(.W(CNT_W), .N(N)) u_out_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clr   (out_clr),
        .inc   (out_xfer),
        .last  (out_last)
    );

    always_comb begin
        state_nxt     = state;
        S_AXIS_TREADY = 1'b0;
        ale_en        = 1'b0;
        te_en         = 1'b0;
        dp_stall      = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        accept        = 1'b0;
        in_clr        = 1'b0;
        out_clr       = 1'b0;
        out_xfer      = 1'b0;
        done_nxt      = 1'b0;
        err_hit       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                err_hit = dp_out_valid;
                if (enable) begin
                    state_nxt = ST_PASS1;
                    in_clr    = 1'b1;
                    out_clr   = 1'b1;
                end
            end
            ST_PASS1: begin
                S_AXIS_TREADY = enable;
                accept        = S_AXIS_TVALID & enable;
                ale_en        = accept;
                err_hit       = dp_out_valid;
                if (accept && in_last) begin
                    state_nxt = ST_WAIT_ALE;
                end
            end
            ST_WAIT_ALE: begin
                err_hit = dp_out_valid;
                if (enable && ale_done) begin
                    state_nxt = ST_PASS2;
                    in_clr    = 1'b1;
                    out_clr   = 1'b1;
                end
            end
            ST_PASS2: begin
                S_AXIS_TREADY = enable & M_AXIS_TREADY;
                accept        = S_AXIS_TVALID & enable & M_AXIS_TREADY;
                te_en         = accept;
                dp_stall      = ~M_AXIS_TREADY | ~enable;
                M_AXIS_TLAST  = dp_out_valid & out_last;
                out_xfer      = dp_out_valid & M_AXIS_TREADY & enable;
                // A zero-latency datapath may finish output before input.
                if (accept && in_last) begin
                    if (out_seen || (out_xfer && out_last)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                dp_stall     = ~M_AXIS_TREADY | ~enable;
                M_AXIS_TLAST = dp_out_valid & out_last;
                out_xfer     = dp_out_valid & M_AXIS_TREADY & enable;
                if (out_xfer && out_last) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        err_hit = enable & (err_hit | (accept & (S_AXIS_TLAST ^ in_last)));
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= ST_IDLE;
            pass_sel    <= PASS_ALE;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            err_framing <= 1'b0;
            out_seen    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
            busy       <= (state_nxt != ST_IDLE);
            pass_sel   <= (state_nxt == ST_PASS2 || state_nxt == ST_DRAIN)
                          ? PASS_TE : PASS_ALE;
            if (err_hit) begin
                err_framing <= 1'b1;
            end
            if (out_clr) begin
                out_seen <= 1'b0;
            end else if (state == ST_PASS2 && out_xfer && out_last) begin
                out_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_haze_pass_sequencer.sv
// Randomised and directed bench for haze_pass_sequencer on a 4x4 frame.
module tb_haze_pass_sequencer;

    localparam int N = 16;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic enable = 1'b0;
    logic s_tvalid = 1'b0;
    logic s_tlast = 1'b0;
    logic m_tready = 1'b0;
    logic dp_out_valid = 1'b0;
    logic ale_done = 1'b0;
    logic s_tready, m_tlast, ale_en, te_en, dp_stall;
    logic pass_sel, frame_done, busy, err_framing;

    int checks = 0;
    int passes = 0;

    // model: phase 0 idle, 1 pass1, 2 wait ale, 3 pass2, 4 drain
    int ph = 0;
    int m_in = 0;
    int m_out = 0;
    bit m_fd = 0;
    bit m_err = 0;

    int n_ale = 0, n_te = 0, n_out = 0, n_tlast = 0, n_fd = 0;
    int tlast_at = -1;

    haze_pass_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .ACLK          (aclk),
        .ARESETn       (aresetn),
        .enable        (enable),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TREADY (m_tready),
        .M_AXIS_TLAST  (m_tlast),
        .dp_out_valid  (dp_out_valid),
        .ale_done      (ale_done),
        .ale_en        (ale_en),
        .te_en         (te_en),
        .dp_stall      (dp_stall),
        .pass_sel      (pass_sel),
        .frame_done    (frame_done),
        .busy          (busy),
        .err_framing   (err_framing)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    always @(negedge aclk) begin
        bit e_rdy, acc, e_ale, e_te, e_stall, e_tl, ox, ofin, outp;
        if (!aresetn) begin
            ph = 0; m_in = 0; m_out = 0; m_fd = 0; m_err = 0;
            chk("rst_tready", s_tready, 0);
            chk("rst_ale_en", ale_en, 0);
            chk("rst_te_en", te_en, 0);
            chk("rst_stall", dp_stall, 0);
            chk("rst_tlast", m_tlast, 0);
            chk("rst_pass_sel", pass_sel, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err_framing, 0);
        end else begin
            outp    = (ph == 3 || ph == 4);
            e_rdy   = enable && (ph == 1 || (ph == 3 && m_tready));
            acc     = e_rdy && s_tvalid;
            e_ale   = (ph == 1) && acc;
            e_te    = (ph == 3) && acc;
            e_stall = outp && !(m_tready && enable);
            e_tl    = outp && dp_out_valid && (m_out == N - 1);
            ox      = outp && dp_out_valid && m_tready && enable;
            chk("tready", s_tready, e_rdy);
            chk("ale_en", ale_en, e_ale);
            chk("te_en", te_en, e_te);
            chk("dp_stall", dp_stall, e_stall);
            chk("m_tlast", m_tlast, e_tl);
            chk("pass_sel", pass_sel, outp);
            chk("busy", busy, ph != 0);
            chk("frame_done", frame_done, m_fd);
            chk("err_framing", err_framing, m_err);
            if (ale_en) n_ale++;
            if (te_en) n_te++;
            if (frame_done) n_fd++;
            if (m_tlast && ox) begin
                n_tlast++;
                tlast_at = n_out;
            end
            if (ox) n_out++;
            m_fd = 0;
            if (enable) begin
                case (ph)
                    0: begin
                        m_err = m_err | dp_out_valid;
                        ph = 1; m_in = 0; m_out = 0;
                    end
                    1: begin
                        m_err = m_err | dp_out_valid;
                        if (acc) begin
                            if (s_tlast != (m_in == N - 1)) m_err = 1;
                            if (m_in == N - 1) ph = 2;
                            m_in++;
                        end
                    end
                    2: begin
                        m_err = m_err | dp_out_valid;
                        if (ale_done) begin
                            ph = 3; m_in = 0; m_out = 0;
                        end
                    end
                    default: begin
                        ofin = ox && (m_out == N - 1);
                        if (ph == 3 && acc) begin
                            if (s_tlast != (m_in == N - 1)) m_err = 1;
                            if (m_in == N - 1) begin
                                if (ofin || m_out >= N) begin
                                    ph = 0; m_fd = 1;
                                end else begin
                                    ph = 4;
                                end
                            end
                            m_in++;
                        end else if (ph == 4 && ofin) begin
                            ph = 0; m_fd = 1;
                        end
                        if (ox) m_out++;
                    end
                endcase
            end
        end
    end

    task automatic run_frame(input int tl_pos, input int rmode, input int gap_at,
                             input int lag, input bit spur, input bit stop_wait,
                             input int exp_err);
        int b_ale, b_te, b_out, b_tl, b_fd;
        int cyc, wcnt, gap_left;
        bit started, ale_sent, gap_done;
        b_ale = n_ale; b_te = n_te; b_out = n_out; b_tl = n_tlast; b_fd = n_fd;
        cyc = 0; wcnt = 0; gap_left = 5;
        started = 0; ale_sent = 0; gap_done = 0;
        while (cyc < 600) begin
            @(posedge aclk); #1;
            cyc++;
            started = started | busy;
            if (stop_wait && !pass_sel && busy && (n_ale - b_ale) == N) break;
            if (started && !busy) break;
            enable = 1'b1;
            if (gap_at >= 0 && !gap_done && pass_sel && (n_te - b_te) == gap_at) begin
                enable = 1'b0;
                gap_left--;
                if (gap_left == 0) gap_done = 1;
            end
            s_tvalid = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rmode == 0) m_tready = 1'b1;
            else if (rmode == 1) m_tready = cyc[0];
            else m_tready = 1'($urandom_range(0, 1));
            s_tlast = pass_sel ? ((n_te - b_te) == N - 1) : ((n_ale - b_ale) == tl_pos);
            ale_done = 1'b0;
            if (!pass_sel && (n_ale - b_ale) == N && !ale_sent) begin
                wcnt++;
                if (wcnt == 3) begin
                    ale_done = 1'b1;
                    ale_sent = 1;
                end
            end
            if (spur && !pass_sel && (n_ale - b_ale) == 5) ale_done = 1'b1;
            dp_out_valid = pass_sel && (n_out - b_out) < N &&
                           ((n_te - b_te) >= (n_out - b_out) + lag || (n_te - b_te) == N);
        end
        enable = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        dp_out_valid = 1'b0; ale_done = 1'b0;
        chk("frame_timeout", int'(cyc >= 600), 0);
        @(negedge aclk);
        @(negedge aclk);
        chk("pass1_beats", n_ale - b_ale, 16);
        if (!stop_wait) begin
            chk("pass2_beats", n_te - b_te, 16);
            chk("out_beats", n_out - b_out, 16);
            chk("tlast_count", n_tlast - b_tl, 1);
            chk("tlast_index", tlast_at - b_out, 15);
            chk("frame_done_count", n_fd - b_fd, 1);
            chk("err_end", err_framing, exp_err);
        end
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_busy", busy, 0);
        run_frame(15, 0, -1, 0, 0, 0, 0);
        run_frame(15, 1, -1, 0, 0, 0, 0);
        run_frame(15, 0, 7, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_frame(15, 2, -1, 2, 0, 0, 0);
        run_frame(15, 0, -1, 0, 0, 1, 0);
        chk("wait_ale_busy", busy, 1);
        @(posedge aclk); #1 aresetn = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pass_sel", pass_sel, 0);
        chk("mid_rst_tready", s_tready, 0);
        @(posedge aclk); #1 aresetn = 1'b1;
        run_frame(15, 0, -1, 1, 0, 0, 0);
        run_frame(9, 0, -1, 0, 0, 0, 1);
        repeat (4) @(negedge aclk);
        chk("err_sticky", err_framing, 1);
        @(posedge aclk); #1 aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        enable = 1'b1; dp_out_valid = 1'b1;
        @(posedge aclk); #1;
        enable = 1'b0; dp_out_valid = 1'b0;
        @(negedge aclk);
        chk("spur_dpv_err", err_framing, 1);
        chk("spur_dpv_busy", busy, 1);
        chk("spur_dpv_pass_sel", pass_sel, 0);
        run_frame(15, 0, -1, 0, 1, 0, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
